// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - password lock controller with lockout, auto-relock and code change
module keypad_lock_ctrl #(
  parameter int                  DIGITS         = 4,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  OPEN_CYCLES    = 500,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter logic [4*DIGITS-1:0] INIT_CODE      = 16'h1234
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          code,
  input  logic                valid,
  input  logic                set_req,
  output logic                open,
  output logic                lock,
  output logic                change,
  output logic                alarm,
  output logic [3:0]          fail_cnt,
  output logic [3:0]          entry_cnt,
  output logic [4*DIGITS-1:0] data
);

  localparam int W    = 4 * DIGITS;
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Timers are loaded with N-1 so the state holds for exactly N cycles.
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    FULL_CNT  = 4'(DIGITS);
  localparam logic [3:0]    FAIL_LIM  = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_OPEN,
    S_CHG_NEW,
    S_CHG_CONFIRM,
    S_LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  stored, stored_n;
  logic [W-1:0]  pending, pending_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    fail_n, entry_n;
  logic [W-1:0]  data_n;
  logic          open_n, change_n, alarm_n;

  logic          key_digit, key_star, key_hash, full;
  logic [W-1:0]  data_shift;

  assign key_digit  = valid && (code <= 4'd9);
  assign key_star   = valid && (code == 4'd10);
  assign key_hash   = valid && (code == 4'd11);
  assign full       = (entry_cnt == FULL_CNT);
  assign data_shift = (data << 4) | W'(code);

  // State and every output are registered together so outputs move one cycle after the key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_LOCKED;
      stored    <= INIT_CODE;
      pending   <= '0;
      timer     <= '0;
      fail_cnt  <= '0;
      entry_cnt <= '0;
      data      <= '0;
      open      <= 1'b0;
      lock      <= 1'b1;
      change    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      stored    <= stored_n;
      pending   <= pending_n;
      timer     <= timer_n;
      fail_cnt  <= fail_n;
      entry_cnt <= entry_n;
      data      <= data_n;
      open      <= open_n;
      lock      <= ~open_n;
      change    <= change_n;
      alarm     <= alarm_n;
    end
  end

  // Next-state, buffer, counter and timer logic.
  always_comb begin
    state_n   = state;
    stored_n  = stored;
    pending_n = pending;
    timer_n   = timer;
    fail_n    = fail_cnt;
    entry_n   = entry_cnt;
    data_n    = data;

    case (state)
      S_LOCKED: begin
        if (key_digit) begin
          if (!full) begin
            data_n  = data_shift;
            entry_n = entry_cnt + 4'd1;
          end
        end else if (key_star) begin
          data_n  = '0;
          entry_n = '0;
        end else if (key_hash) begin
          data_n  = '0;
          entry_n = '0;
          if (full && (data == stored)) begin
            state_n = S_OPEN;
            fail_n  = '0;
            timer_n = OPEN_LOAD;
          end else if (fail_cnt < FAIL_LIM) begin
            fail_n = fail_cnt + 4'd1;
            if (fail_cnt + 4'd1 == FAIL_LIM) begin
              state_n = S_LOCKOUT;
              timer_n = LOCK_LOAD;
            end
          end
        end
      end

      S_OPEN: begin
        // '#' outranks a simultaneous change request.
        if (key_hash) begin
          state_n = S_LOCKED;
          data_n  = '0;
          entry_n = '0;
        end else if (set_req) begin
          state_n = S_CHG_NEW;
          data_n  = '0;
          entry_n = '0;
        end else begin
          if (key_star) begin
            data_n  = '0;
            entry_n = '0;
          end
          if (timer == '0) begin
            state_n = S_LOCKED;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
      end

      S_CHG_NEW, S_CHG_CONFIRM: begin
        // The open timer is frozen here; leaving always reloads it.
        if (key_digit) begin
          if (!full) begin
            data_n  = data_shift;
            entry_n = entry_cnt + 4'd1;
          end
        end else if (key_star) begin
          state_n = S_OPEN;
          timer_n = OPEN_LOAD;
          data_n  = '0;
          entry_n = '0;
        end else if (key_hash) begin
          data_n  = '0;
          entry_n = '0;
          if (state == S_CHG_NEW) begin
            if (full) begin
              pending_n = data;
              state_n   = S_CHG_CONFIRM;
            end
          end else begin
            if (full && (data == pending)) begin
              stored_n = data;
            end
            state_n = S_OPEN;
            timer_n = OPEN_LOAD;
          end
        end
      end

      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_LOCKED;
          fail_n  = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      default: begin
        state_n = S_LOCKED;
      end
    endcase
  end

  // Output decode from the next state, registered alongside it.
  always_comb begin
    open_n   = (state_n == S_OPEN) || (state_n == S_CHG_NEW) || (state_n == S_CHG_CONFIRM);
    change_n = (state_n == S_CHG_NEW) || (state_n == S_CHG_CONFIRM);
    alarm_n  = (state_n == S_LOCKOUT);
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - directed self-checking bench for keypad_lock_ctrl
module tb_keypad_lock_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  code, code6;
  logic        valid, valid6;
  logic        set_req, set_req6;
  logic        open, lock, change, alarm;
  logic [3:0]  fail_cnt, entry_cnt;
  logic [15:0] data;
  logic        open6, lock6, change6, alarm6;
  logic [3:0]  fail_cnt6, entry_cnt6;
  logic [23:0] data6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  keypad_lock_ctrl dut (
    .clock(clock), .reset(reset), .code(code), .valid(valid), .set_req(set_req),
    .open(open), .lock(lock), .change(change), .alarm(alarm),
    .fail_cnt(fail_cnt), .entry_cnt(entry_cnt), .data(data)
  );

  keypad_lock_ctrl #(.DIGITS(6), .INIT_CODE(24'h123456)) dut6 (
    .clock(clock), .reset(reset), .code(code6), .valid(valid6), .set_req(set_req6),
    .open(open6), .lock(lock6), .change(change6), .alarm(alarm6),
    .fail_cnt(fail_cnt6), .entry_cnt(entry_cnt6), .data(data6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse; returns at the negedge after the sampling edge.
  task automatic press(input int sel, input logic [3:0] k);
    if (sel == 0) begin
      code = k; valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
    end else begin
      code6 = k; valid6 = 1'b1;
      @(negedge clock);
      valid6 = 1'b0;
    end
  endtask

  task automatic key(input int sel, input logic [3:0] k);
    press(sel, k);
    repeat (3) @(negedge clock);
  endtask

  // Enters n digits, most significant nibble first.
  task automatic enter(input int sel, input logic [31:0] digs, input int n);
    for (int i = n - 1; i >= 0; i--) key(sel, digs[4*i +: 4]);
  endtask

  task automatic pulse_set;
    set_req = 1'b1;
    @(negedge clock);
    set_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; code = '0; valid = 1'b0; set_req = 1'b0;
    code6 = '0; valid6 = 1'b0; set_req6 = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_open", open, 0);
    check("rst_lock", lock, 1);
    check("rst_change", change, 0);
    check("rst_alarm", alarm, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_entry", entry_cnt, 0);
    check("rst_data", data, 0);
    reset = 1'b1;
    @(negedge clock);

    // Correct code, ignored code 15 mid-entry, then auto-relock timing
    enter(0, 32'h12, 2);
    key(0, 4'd15);
    check("ign15_entry", entry_cnt, 2);
    enter(0, 32'h34, 2);
    check("full_data", data, 16'h1234);
    check("full_entry", entry_cnt, 4);
    press(0, 4'd11);
    check("open_after_hash", open, 1);
    check("lock_after_hash", lock, 0);
    check("buf_cleared", entry_cnt, 0);
    repeat (499) @(negedge clock);
    check("open_last_cycle", open, 1);
    @(negedge clock);
    check("relock_open", open, 0);
    check("relock_lock", lock, 1);

    // Three wrong codes -> lockout of exactly 1000 cycles
    enter(0, 32'h1235, 4); key(0, 4'd11);
    check("fail1", fail_cnt, 1);
    enter(0, 32'h1235, 4); key(0, 4'd11);
    check("fail2", fail_cnt, 2);
    enter(0, 32'h1235, 4); press(0, 4'd11);
    check("fail3", fail_cnt, 3);
    check("alarm_on", alarm, 1);
    press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4); press(0, 4'd11);
    check("lockout_ign_open", open, 0);
    check("lockout_ign_entry", entry_cnt, 0);
    repeat (994) @(negedge clock);
    check("alarm_last_cycle", alarm, 1);
    @(negedge clock);
    check("alarm_off", alarm, 0);
    check("fail_cleared", fail_cnt, 0);
    enter(0, 32'h1234, 4); key(0, 4'd11);
    check("open_after_lockout", open, 1);
    key(0, 4'd11);
    check("hash_relock", open, 0);

    // Fifth digit ignored, then short entry fails
    enter(0, 32'h12345, 5);
    check("no_wrap_data", data, 16'h1234);
    check("no_wrap_entry", entry_cnt, 4);
    key(0, 4'd11);
    check("open_5dig", open, 1);
    key(0, 4'd11);
    enter(0, 32'h12, 2); key(0, 4'd11);
    check("short_fail", fail_cnt, 1);

    // Password change to 9876
    enter(0, 32'h1234, 4); key(0, 4'd11);
    check("open_pre_chg", open, 1);
    check("fail_reset_ok", fail_cnt, 0);
    pulse_set;
    check("chg_enter", change, 1);
    enter(0, 32'h9876, 4); key(0, 4'd11);
    check("chg_confirm_state", change, 1);
    enter(0, 32'h9876, 4); key(0, 4'd11);
    check("chg_done_change", change, 0);
    check("chg_done_open", open, 1);
    key(0, 4'd11);
    enter(0, 32'h1234, 4); key(0, 4'd11);
    check("old_code_fails", fail_cnt, 1);
    check("old_code_closed", open, 0);
    enter(0, 32'h9876, 4); key(0, 4'd11);
    check("new_code_opens", open, 1);

    // Mismatched confirm leaves code unchanged
    pulse_set;
    enter(0, 32'h1111, 4); key(0, 4'd11);
    enter(0, 32'h1112, 4); key(0, 4'd11);
    check("mismatch_open", open, 1);
    check("mismatch_change", change, 0);
    key(0, 4'd11);
    enter(0, 32'h9876, 4); key(0, 4'd11);
    check("code_kept", open, 1);

    // Short new entry stays, '*' cancels, '#' beats set_req
    pulse_set;
    enter(0, 32'h12, 2); key(0, 4'd11);
    check("short_new_stays", change, 1);
    check("short_new_clr", entry_cnt, 0);
    enter(0, 32'h5, 1); key(0, 4'd10);
    check("star_cancel_change", change, 0);
    check("star_cancel_open", open, 1);
    check("star_cancel_entry", entry_cnt, 0);
    set_req = 1'b1;
    press(0, 4'd11);
    set_req = 1'b0;
    check("hash_wins_open", open, 0);
    check("hash_wins_change", change, 0);

    // Async reset mid-entry restores INIT_CODE
    enter(0, 32'h12, 2);
    check("mid_entry", entry_cnt, 2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_entry", entry_cnt, 0);
    check("async_rst_data", data, 0);
    @(negedge clock);
    reset = 1'b1;
    enter(0, 32'h1234, 4); key(0, 4'd11);
    check("init_code_back", open, 1);
    key(0, 4'd11);

    // Reset during lockout
    for (int r = 0; r < 3; r++) begin
      enter(0, 32'h0000, 4); key(0, 4'd11);
    end
    check("lockout2_alarm", alarm, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_lockout_alarm", alarm, 0);
    check("rst_lockout_fail", fail_cnt, 0);
    check("rst_lockout_lock", lock, 1);
    @(negedge clock);
    reset = 1'b1;

    // Six-digit instance
    enter(1, 32'h123456, 6);
    check("d6_data", data6, 24'h123456);
    check("d6_entry", entry_cnt6, 6);
    press(1, 4'd11);
    check("d6_open", open6, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
